// File: rtl/regfile_pkg.sv
// Shared widths and the buffered write-back entry used by the register-file
// write-side controller and its MDU result FIFO.
package regfile_pkg;

  localparam int ADDRESS_WIDTH = 5;
  localparam int DATA_WIDTH    = 32;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for MDU results that lost the write port to the pipeline.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo import regfile_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  wb_entry_t     din,
  output wb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t        mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking; a push and pop in one cycle leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: pipeline writeback first, then buffered or
// bypassed MDU results, with a pending scoreboard for decode hazard stalls.
module regfile_writeback #(
  parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [ADDRESS_WIDTH-1:0] pipe_rd,
  input  logic [DATA_WIDTH-1:0]    pipe_wd,
  input  logic                     mdu_issue,
  input  logic [ADDRESS_WIDTH-1:0] mdu_issue_rd,
  input  logic                     mdu_valid,
  input  logic [ADDRESS_WIDTH-1:0] mdu_rd,
  input  logic [DATA_WIDTH-1:0]    mdu_wd,
  output logic                     mdu_ready,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs1,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs2,
  input  logic [ADDRESS_WIDTH-1:0] chk_rd,
  output logic                     stall,
  output logic                     pending_any,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3
);
  import regfile_pkg::*;

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t               fifo_din_s;
  wb_entry_t               fifo_head_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [CW-1:0]           fifo_count_s;
  logic                    pipe_sel_s;
  logic                    acc_s;
  logic                    bypass_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    sel_we_s;
  logic                    sel_mdu_s;
  logic [ADDRESS_WIDTH-1:0] sel_rd_s;
  logic [DATA_WIDTH-1:0]   sel_wd_s;
  logic [NREG-1:0]         sb_r;
  logic [NREG-1:0]         sb_next_s;
  logic [NREG-1:0]         set_mask_s;
  logic [NREG-1:0]         clr_mask_s;

  assign mdu_ready   = !rst && (fifo_count_s < CW'(FIFO_DEPTH));
  assign pipe_sel_s  = pipe_we && (pipe_rd != {ADDRESS_WIDTH{1'b0}});
  assign acc_s       = mdu_valid && mdu_ready;
  assign bypass_s    = acc_s && (mdu_rd != {ADDRESS_WIDTH{1'b0}}) && fifo_empty_s && !pipe_sel_s;
  assign push_s      = acc_s && (mdu_rd != {ADDRESS_WIDTH{1'b0}}) && !bypass_s && !fifo_full_s;
  assign pop_s       = !pipe_sel_s && !fifo_empty_s;
  assign fifo_din_s  = '{rd: mdu_rd, wd: mdu_wd};
  assign pending_any = |sb_r;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (fifo_din_s),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Write-port selection: pipeline, then FIFO head, then same-cycle MDU bypass.
  always_comb begin
    sel_we_s  = 1'b0;
    sel_mdu_s = 1'b0;
    sel_rd_s  = {ADDRESS_WIDTH{1'b0}};
    sel_wd_s  = {DATA_WIDTH{1'b0}};
    if (pipe_sel_s) begin
      sel_we_s = 1'b1;
      sel_rd_s = pipe_rd;
      sel_wd_s = pipe_wd;
    end else if (pop_s) begin
      sel_we_s  = 1'b1;
      sel_mdu_s = 1'b1;
      sel_rd_s  = fifo_head_s.rd;
      sel_wd_s  = fifo_head_s.wd;
    end else if (bypass_s) begin
      sel_we_s  = 1'b1;
      sel_mdu_s = 1'b1;
      sel_rd_s  = mdu_rd;
      sel_wd_s  = mdu_wd;
    end else begin
      sel_we_s  = 1'b0;
      sel_mdu_s = 1'b0;
    end
  end

  // Scoreboard update; an issue to the same register as a committing result wins.
  always_comb begin
    set_mask_s = {NREG{1'b0}};
    clr_mask_s = {NREG{1'b0}};
    if (mdu_issue && (mdu_issue_rd != {ADDRESS_WIDTH{1'b0}})) begin
      set_mask_s[mdu_issue_rd] = 1'b1;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (sel_we_s && sel_mdu_s) begin
      clr_mask_s[sel_rd_s] = 1'b1;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    sb_next_s    = (sb_r & ~clr_mask_s) | set_mask_s;
    sb_next_s[0] = 1'b0;
  end

  // Pending-result scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_r <= {NREG{1'b0}};
    end else begin
      sb_r <= sb_next_s;
    end
  end

  // Decode hazard check; register 0 is never pending.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else begin
      stall = ((chk_rs1 != {ADDRESS_WIDTH{1'b0}}) && sb_r[chk_rs1]) ||
              ((chk_rs2 != {ADDRESS_WIDTH{1'b0}}) && sb_r[chk_rs2]) ||
              ((chk_rd  != {ADDRESS_WIDTH{1'b0}}) && sb_r[chk_rd]);
    end
  end

  // Registered write port; address and data hold when no write is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      WE3 <= 1'b0;
      AD3 <= {ADDRESS_WIDTH{1'b0}};
      WD3 <= {DATA_WIDTH{1'b0}};
    end else begin
      WE3 <= sel_we_s;
      if (sel_we_s) begin
        AD3 <= sel_rd_s;
        WD3 <= sel_wd_s;
      end
    end
  end

endmodule
